// File: rtl/rr_arbiter_pkg.sv
// Shared helpers for the round-robin arbiter slice.
package rr_arbiter_pkg;

  // Width of a binary select for n inputs. It is kept at least 1 so that a
  // single-input arbiter still has a real sel port for the multiplexer.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_prio_encoder.sv
// Rotating priority encoder. It finds the lowest set request at or above ptr
// and falls back to the lowest set request overall, which gives the wrap.
module rr_prio_encoder #(
  parameter int NumInputs = 2,
  parameter int SelWidth  = 1
) (
  input  logic [NumInputs-1:0] req,
  input  logic [SelWidth-1:0]  ptr,
  output logic [SelWidth-1:0]  idx,
  output logic                 found
);

  logic [NumInputs-1:0] w_masked;
  logic [SelWidth-1:0]  w_masked_idx;
  logic [SelWidth-1:0]  w_plain_idx;

  // Clear requests that sit below the current highest-priority index.
  always_comb begin
    w_masked = '0;
    for (int i = 0; i < NumInputs; i++) begin
      w_masked[i] = req[i] && (i >= int'(ptr));
    end
  end

  // Lowest set bit of both vectors. The loop runs downward so that the
  // lowest index is the one left assigned.
  // NOTE: every always_comb output gets a default first; otherwise any path
  // that skips an assignment would infer a latch.
  always_comb begin
    w_masked_idx = '0;
    w_plain_idx  = '0;
    for (int i = NumInputs - 1; i >= 0; i--) begin
      if (w_masked[i]) w_masked_idx = SelWidth'(i);
      if (req[i])      w_plain_idx  = SelWidth'(i);
    end
  end

  // Prefer the masked search and wrap to the unmasked one when it is empty.
  always_comb begin
    found = |req;
    idx   = (|w_masked) ? w_masked_idx : w_plain_idx;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin valid/ready arbiter. It drives the select of a downstream mux
// and holds that select steady while the consumer stalls.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter  int NumInputs = 2,
  localparam int SelWidth  = sel_width(NumInputs)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumInputs-1:0] req_i,
  output logic [NumInputs-1:0] gnt_o,
  output logic [NumInputs-1:0] grant_o,
  output logic [SelWidth-1:0]  sel_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  logic [SelWidth-1:0]  r_ptr;
  logic                 r_locked;
  logic [SelWidth-1:0]  r_lock_sel;

  logic [SelWidth-1:0]  w_enc_idx;
  logic                 w_enc_found;
  logic                 w_lock_req;
  logic [SelWidth-1:0]  w_sel;
  logic                 w_valid;
  logic [NumInputs-1:0] w_grant;
  logic [SelWidth-1:0]  w_ptr_next;

  rr_prio_encoder #(
    .NumInputs (NumInputs),
    .SelWidth  (SelWidth)
  ) u_prio_encoder (
    .req   (req_i),
    .ptr   (r_ptr),
    .idx   (w_enc_idx),
    .found (w_enc_found)
  );

  // Look up the locked requester's valid without indexing past NumInputs.
  always_comb begin
    w_lock_req = 1'b0;
    for (int i = 0; i < NumInputs; i++) begin
      if (r_lock_sel == SelWidth'(i)) w_lock_req = req_i[i];
    end
  end

  // A lock holds the stalled selection; otherwise the rotating search decides.
  always_comb begin
    w_sel   = '0;
    w_valid = 1'b0;
    if (r_locked) begin
      w_sel   = r_lock_sel;
      w_valid = w_lock_req;
    end else if (w_enc_found) begin
      w_sel   = w_enc_idx;
      w_valid = 1'b1;
    end
  end

  // Build the one-hot grant and the next pointer. The wrap is an explicit
  // compare, so non-power-of-2 input counts never reach an unused index.
  always_comb begin
    w_grant = '0;
    for (int i = 0; i < NumInputs; i++) begin
      if (w_valid && (w_sel == SelWidth'(i))) w_grant[i] = 1'b1;
    end
    w_ptr_next = (w_sel == SelWidth'(NumInputs - 1)) ? '0 : w_sel + SelWidth'(1);
  end

  // Rotate priority on a handshake, lock on a stall, and drop the lock when
  // the locked requester withdraws. Reset wins over everything else.
  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the values from before the clock edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr      <= '0;
      r_locked   <= 1'b0;
      r_lock_sel <= '0;
    end else if (w_valid && ready_i) begin
      r_ptr    <= w_ptr_next;
      r_locked <= 1'b0;
    end else if (w_valid) begin
      r_locked   <= 1'b1;
      r_lock_sel <= w_sel;
    end else begin
      r_locked <= 1'b0;
    end
  end

  assign sel_o   = w_sel;
  assign valid_o = w_valid;
  assign grant_o = w_grant;
  assign gnt_o   = w_grant & {NumInputs{ready_i}};

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter with a 4-input and a 3-input instance.
// A behavioural model, stepped once per cycle, predicts every output.
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req4 = '0;
  logic       rdy4 = 1'b0;
  logic [2:0] req3 = '0;
  logic       rdy3 = 1'b0;

  logic [3:0] gnt4, grant4;
  logic [1:0] sel4;
  logic       valid4;
  logic [2:0] gnt3, grant3;
  logic [1:0] sel3;
  logic       valid3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_arbiter #(.NumInputs(4)) dut4 (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req4),
    .gnt_o   (gnt4),
    .grant_o (grant4),
    .sel_o   (sel4),
    .valid_o (valid4),
    .ready_i (rdy4)
  );

  rr_arbiter #(.NumInputs(3)) dut3 (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req3),
    .gnt_o   (gnt3),
    .grant_o (grant3),
    .sel_o   (sel3),
    .valid_o (valid3),
    .ready_i (rdy3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model state: priority start, lock flag and locked index.
  int m4_ptr, m4_lsel, m3_ptr, m3_lsel;
  bit m4_locked, m3_locked;
  bit model_ready = 1'b0;

  // Rule: a locked requester keeps the selection; otherwise scan n indices
  // starting at ptr, modulo n, and take the first requester seen.
  function automatic void model_out(input int n, input int ptr, input bit locked,
                                    input int lsel, input logic [3:0] req,
                                    output bit v, output int sel);
    v   = 1'b0;
    sel = 0;
    if (locked) begin
      sel = lsel;
      v   = req[lsel];
    end else begin
      for (int k = 0; k < n; k++) begin
        int idx;
        idx = (ptr + k) % n;
        if (!v && req[idx]) begin
          v   = 1'b1;
          sel = idx;
        end
      end
    end
  endfunction

  function automatic void model_step(input int n, input bit v, input int sel, input bit rdy,
                                     inout int ptr, inout bit locked, inout int lsel);
    if (v && rdy) begin
      ptr    = (sel + 1) % n;
      locked = 1'b0;
    end else if (v) begin
      locked = 1'b1;
      lsel   = sel;
    end else begin
      locked = 1'b0;
    end
  endfunction

  // Compare process: on each falling edge, check outputs, then advance the model.
  always @(negedge clk) begin
    bit         v4, v3;
    int         s4, s3;
    logic [3:0] g4;
    logic [2:0] g3;
    model_out(4, m4_ptr, m4_locked, m4_lsel, req4, v4, s4);
    model_out(3, m3_ptr, m3_locked, m3_lsel, {1'b0, req3}, v3, s3);
    g4 = v4 ? 4'(1 << s4) : 4'b0;
    g3 = v3 ? 3'(1 << s3) : 3'b0;
    if (model_ready) begin
      check("n4_valid", 32'(valid4), 32'(v4));
      check("n4_sel",   32'(sel4),   32'(s4));
      check("n4_grant", 32'(grant4), 32'(g4));
      check("n4_gnt",   32'(gnt4),   32'(g4 & {4{rdy4}}));
      check("n3_valid", 32'(valid3), 32'(v3));
      check("n3_sel",   32'(sel3),   32'(s3));
      check("n3_grant", 32'(grant3), 32'(g3));
      check("n3_gnt",   32'(gnt3),   32'(g3 & {3{rdy3}}));
    end
    if (rst) begin
      m4_ptr = 0; m4_locked = 1'b0; m4_lsel = 0;
      m3_ptr = 0; m3_locked = 1'b0; m3_lsel = 0;
      model_ready = 1'b1;
    end else if (model_ready) begin
      model_step(4, v4, s4, rdy4, m4_ptr, m4_locked, m4_lsel);
      model_step(3, v3, s3, rdy3, m3_ptr, m3_locked, m3_lsel);
    end
  end

  // Apply one cycle of inputs just after the rising edge, then return just
  // after the falling edge so that literal checks see settled outputs.
  task automatic drive(input logic r, input logic [3:0] q4, input logic y4,
                       input logic [2:0] q3, input logic y3);
    @(posedge clk);
    #1;
    rst  = r;
    req4 = q4;
    rdy4 = y4;
    req3 = q3;
    rdy3 = y3;
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset, then idle: every output must be zero.
    drive(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);
    drive(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);
    drive(1'b0, 4'b0000, 1'b1, 3'b000, 1'b1);
    check("rst_valid", 32'(valid4), 32'd0);
    check("rst_sel",   32'(sel4),   32'd0);
    check("rst_grant", 32'(grant4), 32'd0);
    check("rst_gnt",   32'(gnt4),   32'd0);

    // Full load: one handshake per cycle, sel rotates 0,1,2,3,0,1.
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 4'b1111, 1'b1, 3'b000, 1'b0);
      check("full_sel", 32'(sel4), 32'(k % 4));
      check("full_gnt", 32'(gnt4), 32'(1 << (k % 4)));
    end

    // Sparse requests 1010 from ptr 0: sel 1,3,1,3.
    drive(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 4'b1010, 1'b1, 3'b000, 1'b0);
      check("sparse_sel",   32'(sel4),   (k % 2 == 0) ? 32'd1 : 32'd3);
      check("sparse_grant", 32'(grant4), (k % 2 == 0) ? 32'h2 : 32'h8);
    end

    // Stall: lock on index 2 while lower-index requests arrive.
    drive(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);
    drive(1'b0, 4'b0100, 1'b0, 3'b000, 1'b0);
    check("stall_sel0",   32'(sel4),   32'd2);
    check("stall_valid0", 32'(valid4), 32'd1);
    check("stall_gnt0",   32'(gnt4),   32'd0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 4'b0111, 1'b0, 3'b000, 1'b0);
      check("stall_sel", 32'(sel4), 32'd2);
      check("stall_gnt", 32'(gnt4), 32'd0);
    end
    drive(1'b0, 4'b0111, 1'b1, 3'b000, 1'b0);
    check("release_sel", 32'(sel4), 32'd2);
    check("release_gnt", 32'(gnt4), 32'h4);
    drive(1'b0, 4'b0011, 1'b1, 3'b000, 1'b0);
    check("after_release_sel", 32'(sel4), 32'd0);

    // Reset mid-stall: ptr to 3, lock on 3, then reset restarts at 0.
    drive(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);
    drive(1'b0, 4'b0100, 1'b1, 3'b000, 1'b0);
    drive(1'b0, 4'b1001, 1'b0, 3'b000, 1'b0);
    check("lock3_sel", 32'(sel4), 32'd3);
    drive(1'b0, 4'b1001, 1'b0, 3'b000, 1'b0);
    check("lock3_hold", 32'(sel4), 32'd3);
    drive(1'b1, 4'b1001, 1'b0, 3'b000, 1'b0);
    drive(1'b0, 4'b1001, 1'b0, 3'b000, 1'b0);
    check("post_rst_sel",   32'(sel4),   32'd0);
    check("post_rst_valid", 32'(valid4), 32'd1);

    // Three inputs: explicit wrap after index 2.
    drive(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 4'b0000, 1'b0, 3'b111, 1'b1);
      check("n3_wrap_sel", 32'(sel3), 32'(k % 3));
    end

    // Random traffic, with occasional resets, for both instances.
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 63) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
            3'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that selects one of `NumInputs` valid/ready requesters and drives the select index of the downstream `multiplexer` (`sel_o` → `sel_i`). Requester payloads are packed into the mux's `data_i`; the arbiter only handles the control path. It sits between shared-resource clients (e.g. fetch/LSU memory ports) and the single consumer. It guarantees fair rotation and a stable selection while the consumer stalls.

## Interface
- `NumInputs`, default 2: number of requesters, ≥1.
- `SelWidth`, localparam: `(NumInputs > 1) ? $clog2(NumInputs) : 1`.

Ports:
- `clk_i`  input  1  clock; all state updates on the rising edge.
- `rst_i`  input  1  reset, synchronous, active-high.
- `req_i`  input  NumInputs  per-requester valid.
- `gnt_o`  output  NumInputs  per-requester ready (one-hot or zero): `grant_o & {NumInputs{ready_i}}`.
- `grant_o`  output  NumInputs  one-hot of the currently selected requester; zero when `valid_o`=0.
- `sel_o`  output  SelWidth  binary index of the selected requester; connects to `multiplexer.sel_i`.
- `valid_o`  output  1  downstream valid.
- `ready_i`  input  1  downstream ready.

## Operation
- State:
  - `ptr` is the highest-priority index, range 0..NumInputs-1.
  - `locked` is 1 bit.
  - `lock_sel` has width SelWidth.
- Unlocked selection:
  - Search `req_i` starting at `ptr` upward, then wrap from 0 to `ptr-1`.
  - The first set bit gives `sel_o`, and `valid_o`=1.
  - If no request is set: `valid_o`=0, `sel_o`=0, `grant_o`=0.
- Locked selection:
  - `sel_o`=`lock_sel` and `valid_o`=`req_i[lock_sel]`.
  - Other requests are ignored, including higher-priority ones.
- Handshake happens when `valid_o && ready_i`:
  - `ptr` ← `sel_o+1`, wrapping to 0 when `sel_o`=NumInputs-1. The wrap is explicit, so non-power-of-2 counts are supported.
  - `locked` ← 0.
- Stall happens when `valid_o && !ready_i`:
  - `locked` ← 1 and `lock_sel` ← `sel_o`.
  - `ptr` is unchanged.
- Requesters must hold `req_i` until granted. If a locked requester drops `req_i`, `valid_o` falls and the lock is released next cycle. `ptr` is unchanged in that case.
- Handshake and new requests in the same cycle: the new requests take part in the next cycle's search using the updated `ptr`.
- NumInputs=1:
  - `sel_o` is tied to 0 and `ptr` stays 0.
  - `valid_o`=`req_i[0]`.
- Reset values: `ptr`=0, `locked`=0, `lock_sel`=0. Outputs are combinational from this state and `req_i`. With no requests after reset, all outputs are 0.

## Timing
- Zero-latency path: `req_i`/`ready_i` → `sel_o`/`valid_o`/`grant_o`/`gnt_o`. There is no register on the grant path.
- A transfer completes in the same cycle `valid_o && ready_i` is observed.
- Priority rotation takes effect the cycle after the handshake.
- `sel_o` is stable from the first cycle of a stall until the handshake cycle inclusive.
- `rst_i` asserted mid-stall: the lock is cleared and `ptr`=0 on the next edge. Selection then restarts from index 0. `rst_i` overrides any same-cycle handshake update.

## Structure
- No shared package types are needed; `SelWidth` is a module localparam computed identically to `multiplexer`.
- One natural sub-module: `rr_prio_encoder`.
  - Combinational.
  - Inputs: `req`, `ptr`. Outputs: `idx`, `found`.
  - Implementation: a masked search (`req` with bits below `ptr` cleared) followed by an unmasked fallback.
- The top level holds the `ptr`/lock registers and the output muxing.

## Test plan
NumInputs=4 unless stated.
- **Reset:** `rst_i`=1 for 2 cycles, then `req_i`=0000 → `valid_o`=0, `sel_o`=0, `grant_o`=0000, `gnt_o`=0000.
- **Full load:** `req_i`=1111, `ready_i`=1 constant → `sel_o` sequence 0,1,2,3,0,1 with one handshake per cycle.
- **Sparse:** `req_i`=1010, `ready_i`=1 → `sel_o` 1,3,1,3; `grant_o` 0010,1000,….
- **Stall lock:**
  - Setup: `req_i`=0100, `ready_i`=0 for 3 cycles.
  - Then `req_i`=0111 during the stall → `sel_o`=2 held all 3 cycles, `gnt_o`=0000.
  - Release: `ready_i`=1 → handshake on index 2, then `sel_o`=0 next cycle (wrap from `ptr`=3 finds no req at 3, then finds 0).
- **Reset mid-stall:**
  - Setup: locked on `sel_o`=3 with `req_i`=1001.
  - Stimulus: pulse `rst_i` → next cycle `sel_o`=0, `valid_o`=1.
- **NumInputs=3 wrap:** `req_i`=111, `ready_i`=1 → `sel_o` 0,1,2,0. `ptr` never takes the value 3.
